raymarch_frame_scheduler: RTL and testbench

Drives the pixel-coordinate side of the raymarcher: presents curr_x/curr_y, consumes the color result on each pixel_done, and writes it into the frame buffer as RGB565. It walks the screen in raster order, counts frames and flags frame completion. It sits between the raymarcher core and the frame-buffer BRAM write port.

---
 rtl/raymarch_frame_scheduler.sv | 131 +++++++++++++
 tb/tb_raymarch_frame_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/raymarch_frame_scheduler.sv
// Raster-order pixel scheduler between the raymarcher core and the frame-buffer write port.
// Tracks the pixel in flight, writes each result as RGB565 and counts completed frames.
module raymarch_frame_scheduler #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720
) (
  input  logic                                        clk_pixel_in,
  input  logic                                        rst_in,
  input  logic                                        render_en,
  input  logic                                        pixel_done,
  input  logic [7:0]                                  red_in,
  input  logic [7:0]                                  green_in,
  input  logic [7:0]                                  blue_in,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]   curr_x,
  output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] curr_y,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]              fb_addr,
  output logic [15:0]                                  fb_data,
  output logic                                         fb_we,
  output logic                                         frame_done,
  output logic [7:0]                                   frame_count,
  output logic                                         busy
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          w_accept;
  logic          w_last;
  logic          w_x_last;
  logic [15:0]   w_rgb565;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_fb_addr;
  logic [15:0]   r_fb_data;
  logic          r_fb_we;
  logic          r_frame_done;
  logic [7:0]    r_frame_count;

  assign w_x_last = (r_x == X_LAST);
  assign w_last   = w_x_last && (r_y == Y_LAST);
  assign w_rgb565 = {red_in[7:3], green_in[7:2], blue_in[7:3]};

  // Next state and result-accept decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (render_en) w_next_state = ST_PRIME;
        else           w_next_state = ST_IDLE;
      end
      // The pixel in flight at start-up has unknown coordinates, so its result is dropped.
      ST_PRIME: begin
        if (pixel_done) w_next_state = ST_RUN;
        else            w_next_state = ST_PRIME;
      end
      ST_RUN: begin
        if (pixel_done) begin
          w_accept = 1'b1;
          if (w_last && !render_en) w_next_state = ST_IDLE;
          else                      w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Coordinate/address walk, frame-buffer write and frame counting
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_x           <= '0;
      r_y           <= '0;
      r_addr        <= '0;
      r_fb_addr     <= '0;
      r_fb_data     <= 16'h0000;
      r_fb_we       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_fb_we      <= w_accept;
      r_frame_done <= w_accept && w_last;
      if (w_accept) begin
        r_fb_addr <= r_addr;
        r_fb_data <= w_rgb565;
        if (w_last) begin
          r_x           <= '0;
          r_y           <= '0;
          r_addr        <= '0;
          r_frame_count <= r_frame_count + 8'd1;
        end else if (w_x_last) begin
          r_x    <= '0;
          r_y    <= r_y + YW'(1);
          r_addr <= r_addr + AW'(1);
        end else begin
          r_x    <= r_x + XW'(1);
          r_addr <= r_addr + AW'(1);
        end
      end
    end
  end

  assign curr_x      = r_x;
  assign curr_y      = r_y;
  assign fb_addr     = r_fb_addr;
  assign fb_data     = r_fb_data;
  assign fb_we       = r_fb_we;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Directed bench for raymarch_frame_scheduler on a 4x3 screen.
module tb_raymarch_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        render_en;
  logic        pixel_done;
  logic [7:0]  red_in, green_in, blue_in;
  logic [1:0]  curr_x;
  logic [1:0]  curr_y;
  logic [3:0]  fb_addr;
  logic [15:0] fb_data;
  logic        fb_we;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_frame_done = 0;

  always #5 clk = ~clk;

  raymarch_frame_scheduler #(.WIDTH(4), .HEIGHT(3)) dut (
    .clk_pixel_in(clk),
    .rst_in(rst_in),
    .render_en(render_en),
    .pixel_done(pixel_done),
    .red_in(red_in),
    .green_in(green_in),
    .blue_in(blue_in),
    .curr_x(curr_x),
    .curr_y(curr_y),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .fb_we(fb_we),
    .frame_done(frame_done),
    .frame_count(frame_count),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel_done strobe; returns at the negedge after the capturing edge.
  task automatic pulse(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pixel_done = 1'b1;
    red_in = r; green_in = g; blue_in = b;
    @(negedge clk);
    pixel_done = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; render_en = 1'b0; pixel_done = 1'b0;
    red_in = 8'h00; green_in = 8'h00; blue_in = 8'h00;
    @(negedge clk); @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    check("rst_x", 32'(curr_x), 32'd0);
    check("rst_y", 32'(curr_y), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_data", 32'(fb_data), 32'd0);
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // IDLE ignores results
    pulse(8'hFF, 8'hFF, 8'hFF);
    check("idle_we", 32'(fb_we), 32'd0);

    render_en = 1'b1;
    @(negedge clk);
    check("prime_busy", 32'(busy), 32'd1);
    pulse(8'hFF, 8'h00, 8'hFF);
    check("prime_we", 32'(fb_we), 32'd0);
    check("prime_x", 32'(curr_x), 32'd0);
    check("prime_y", 32'(curr_y), 32'd0);

    // Frame 1, render_en dropped at pixel 6
    for (int k = 0; k < 12; k++) begin
      if (k == 6) render_en = 1'b0;
      pulse(8'hFF, 8'h00, 8'hFF);
      check("f1_we", 32'(fb_we), 32'd1);
      check("f1_addr", 32'(fb_addr), 32'(k));
      check("f1_data", 32'(fb_data), 32'hF81F);
      check("f1_fd", 32'(frame_done), (k == 11) ? 32'd1 : 32'd0);
      if (k == 3) begin
        check("wrap_x", 32'(curr_x), 32'd0);
        check("wrap_y", 32'(curr_y), 32'd1);
      end
      if (k == 4) begin
        check("trk_x", 32'(curr_x), 32'd1);
        check("trk_y", 32'(curr_y), 32'd1);
      end
    end
    check("f1_fc", 32'(frame_count), 32'd1);
    check("f1_end_x", 32'(curr_x), 32'd0);
    check("f1_end_y", 32'(curr_y), 32'd0);
    check("f1_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("gap_we", 32'(fb_we), 32'd0);
    check("gap_fd", 32'(frame_done), 32'd0);
    pulse(8'h12, 8'h34, 8'h56);
    check("after_stop_we", 32'(fb_we), 32'd0);

    // Continuous rendering: one discard then two full frames
    render_en = 1'b1;
    @(negedge clk);
    pulse(8'h00, 8'hFF, 8'h00);
    check("c_prime_we", 32'(fb_we), 32'd0);
    n_frame_done = 0;
    for (int k = 0; k < 24; k++) begin
      pulse(8'h00, 8'hFF, 8'h00);
      if (frame_done === 1'b1) n_frame_done++;
      check("c_we", 32'(fb_we), 32'd1);
      check("c_addr", 32'(fb_addr), 32'(k % 12));
      check("c_data", 32'(fb_data), 32'h07E0);
    end
    check("c_nfd", 32'(n_frame_done), 32'd2);
    check("c_fc", 32'(frame_count), 32'd3);
    check("c_busy", 32'(busy), 32'd1);

    // Back-to-back results
    pixel_done = 1'b1;
    red_in = 8'hFF; green_in = 8'hFF; blue_in = 8'hFF;
    @(negedge clk);
    check("b2b_we0", 32'(fb_we), 32'd1);
    check("b2b_data0", 32'(fb_data), 32'hFFFF);
    check("b2b_addr0", 32'(fb_addr), 32'd0);
    red_in = 8'h00; green_in = 8'h00; blue_in = 8'h00;
    @(negedge clk);
    pixel_done = 1'b0;
    check("b2b_we1", 32'(fb_we), 32'd1);
    check("b2b_data1", 32'(fb_data), 32'h0000);
    check("b2b_addr1", 32'(fb_addr), 32'd1);
    check("b2b_x", 32'(curr_x), 32'd2);

    // Reset coincident with a result mid-frame
    pixel_done = 1'b1; rst_in = 1'b1;
    red_in = 8'hFF; green_in = 8'hFF; blue_in = 8'hFF;
    @(negedge clk);
    pixel_done = 1'b0; rst_in = 1'b0;
    check("mrst_we", 32'(fb_we), 32'd0);
    check("mrst_x", 32'(curr_x), 32'd0);
    check("mrst_y", 32'(curr_y), 32'd0);
    check("mrst_fc", 32'(frame_count), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_addr", 32'(fb_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
